// File: rtl/quad_enc_counter.sv
// Quadrature encoder front end: two-flop synchroniser, level de-glitch
// filter, x4/x1 direction decode and a saturating signed step counter that
// the downstream window sampler clears once per sample window.
//
// state       | meaning
// ------------+------------------------------------------------------------
// filt        | last accepted (de-glitched) {A,B} level, 00 after reset
// cand/fcnt   | level currently being qualified and how long it has held
// count/flags | steps since the last win_clr, sticky err/ovf
module quad_enc_counter #(
   parameter int CNT_W    = 8,
   parameter int FILT_LEN = 4,
   parameter int X4_MODE  = 1
) (
   input  logic                    clk,
   input  logic                    rese,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    win_clr,
   output logic signed [CNT_W-1:0] count,
   output logic                    dir,
   output logic                    step,
   output logic                    err,
   output logic                    ovf
);

   // Filter counter saturates here; a level is accepted on the edge where it
   // is still stable with the counter already at this value, which places the
   // count update FILT_LEN+3 edges after the pin change.
   localparam logic [3:0] FILT_TC = 4'(FILT_LEN - 1);
   localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

   logic [1:0] sync1, sync2, cand, filt;
   logic [3:0] fcnt;

   logic                    accept;
   logic [1:0]              idx_old, idx_new, delta;
   logic                    mv_fwd, mv_rev, mv_bad;
   logic                    cnt_up, cnt_dn;
   logic signed [CNT_W-1:0] count_base, count_nxt;
   logic                    err_nxt, ovf_nxt, step_nxt;

   // Gray level to position: 00->0, 01->1, 11->2, 10->3
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   // Decode the accepted transition and compute the next counter/flag values
   always_comb begin
      accept  = (sync2 == cand) && (fcnt == FILT_TC) && (cand != filt);
      idx_old = gray_pos(filt);
      idx_new = gray_pos(cand);
      delta   = idx_new - idx_old;
      mv_fwd  = accept && (delta == 2'd1);
      mv_rev  = accept && (delta == 2'd3);
      mv_bad  = accept && (delta == 2'd2);

      if (X4_MODE != 0) begin
         cnt_up = mv_fwd;
         cnt_dn = mv_rev;
      end else begin
         cnt_up = mv_fwd && (filt == 2'b10) && (cand == 2'b00);
         cnt_dn = mv_rev && (filt == 2'b00) && (cand == 2'b10);
      end

      // A window clear zeroes the accumulator first so a coincident step
      // lands in the new window instead of being lost.
      count_base = win_clr ? '0 : count;
      err_nxt    = win_clr ? 1'b0 : err;
      ovf_nxt    = win_clr ? 1'b0 : ovf;
      count_nxt  = count_base;
      step_nxt   = 1'b0;

      if (mv_bad) begin
         err_nxt = 1'b1;
      end else if (cnt_up) begin
         step_nxt = 1'b1;
         if (count_base == CNT_MAX) ovf_nxt = 1'b1;
         else                       count_nxt = count_base + CNT_W'(1);
      end else if (cnt_dn) begin
         step_nxt = 1'b1;
         if (count_base == CNT_MIN) ovf_nxt = 1'b1;
         else                       count_nxt = count_base - CNT_W'(1);
      end
   end

   // Synchroniser, filter, filtered level and counter registers
   always_ff @(posedge clk) begin
      if (rese) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
         cand  <= 2'b00;
         filt  <= 2'b00;
         fcnt  <= 4'd0;
         count <= '0;
         dir   <= 1'b0;
         step  <= 1'b0;
         err   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         sync1 <= {enc_a, enc_b};
         sync2 <= sync1;

         if (sync2 != cand) begin
            cand <= sync2;
            fcnt <= 4'd0;
         end else if (fcnt != FILT_TC) begin
            fcnt <= fcnt + 4'd1;
         end

         if (accept) filt <= cand;
         if (mv_fwd || mv_rev) dir <= mv_fwd;

         count <= count_nxt;
         step  <= step_nxt;
         err   <= err_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule
